dp_ram_port_ctrl: RTL and testbench

//  Initiator for one port of dp_ram. Takes valid/ready read/write requests and drives the

---
 rtl/dp_ram_port_ctrl.sv | 149 ++++++++++++++
 tb/tb_dp_ram_port_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dp_ram_port_ctrl
//  Purpose  : Initiator for one port of dp_ram. It accepts valid/ready
//             read/write requests and drives the port's address, write data
//             and byte-lane write enables. It returns read data or write
//             status on a valid/ready response channel. A write that the RAM
//             suppresses through arbitration is reissued unchanged. After
//             MAX_RETRY failed attempts it is abandoned with RSP_ERR=1.
//  Ports    : CLK, RST_N (async, active low)
//             REQ_VALID/REQ_READY/REQ_WRITE/REQ_ADDR/REQ_WDATA/REQ_STRB
//                          request channel
//             RSP_VALID/RSP_READY/RSP_RDATA/RSP_ERR
//                          response channel
//             MEM_ADDR/MEM_W_DATA/MEM_W_EN
//                          to the RAM port
//             MEM_R_DATA/MEM_ARB_ERR
//                          from the RAM port (combinational read)
//  Revision : 1.0  initial release
// ============================================================================
module dp_ram_port_ctrl #(
   parameter  int WIDTH         = 8,
   parameter  int DEPTH         = 8,
   parameter  int STRB_WIDTH    = 8,
   parameter  int MAX_RETRY     = 4,
   localparam int c_ADDR_WIDTH  = $clog2(DEPTH),
   localparam int c_WE_WIDTH    = WIDTH / STRB_WIDTH,
   localparam int c_RETRY_WIDTH = $clog2(MAX_RETRY + 1)
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    REQ_VALID,
   output logic                    REQ_READY,
   input  logic                    REQ_WRITE,
   input  logic [c_ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [WIDTH-1:0]        REQ_WDATA,
   input  logic [c_WE_WIDTH-1:0]   REQ_STRB,
   output logic                    RSP_VALID,
   input  logic                    RSP_READY,
   output logic [WIDTH-1:0]        RSP_RDATA,
   output logic                    RSP_ERR,
   output logic [c_ADDR_WIDTH-1:0] MEM_ADDR,
   output logic [WIDTH-1:0]        MEM_W_DATA,
   output logic [c_WE_WIDTH-1:0]   MEM_W_EN,
   input  logic [WIDTH-1:0]        MEM_R_DATA,
   input  logic                    MEM_ARB_ERR
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [c_RETRY_WIDTH-1:0] c_RETRY_LIMIT = c_RETRY_WIDTH'(MAX_RETRY);

   state_t                    r_state;
   logic                      r_ready_en;
   logic                      r_write;
   logic [c_ADDR_WIDTH-1:0]   r_addr;
   logic [WIDTH-1:0]          r_wdata;
   logic [c_WE_WIDTH-1:0]     r_strb;
   logic [c_RETRY_WIDTH-1:0]  r_retry;
   logic [WIDTH-1:0]          r_rsp_rdata;
   logic                      r_rsp_err;

   logic                      w_req_ready;
   logic                      w_accept;
   logic [c_RETRY_WIDTH-1:0]  w_retry_nxt;

   // r_ready_en keeps REQ_READY low for the first cycle after reset release.
   // In RESP a new request may only enter on the same edge as the response
   // handshake, so REQ_READY follows RSP_READY there.
   assign w_req_ready = r_ready_en &&
                        ((r_state == S_IDLE) || ((r_state == S_RESP) && RSP_READY));
   assign w_accept    = REQ_VALID && w_req_ready;
   assign w_retry_nxt = r_retry + c_RETRY_WIDTH'(1);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_ready_en  <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_strb      <= '0;
         r_retry     <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;

         // Command capture happens only on the accept edge.
         if (w_accept) begin
            r_write <= REQ_WRITE;
            r_addr  <= REQ_ADDR;
            r_wdata <= REQ_WDATA;
            r_strb  <= REQ_STRB;
            r_retry <= '0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!r_write) begin
                  r_rsp_rdata <= MEM_R_DATA;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
               end else if (!MEM_ARB_ERR || (r_strb == '0)) begin
                  // An all-zero strobe write touches nothing, so an
                  // arbitration loss on it is not worth retrying.
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
               end else begin
                  r_retry <= w_retry_nxt;
                  if (w_retry_nxt == c_RETRY_LIMIT) begin
                     r_rsp_rdata <= '0;
                     r_rsp_err   <= 1'b1;
                     r_state     <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (RSP_READY) begin
                  r_state <= REQ_VALID ? S_ACCESS : S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign REQ_READY  = w_req_ready;
   assign RSP_VALID  = (r_state == S_RESP);
   assign RSP_RDATA  = r_rsp_rdata;
   assign RSP_ERR    = r_rsp_err;
   assign MEM_ADDR   = r_addr;
   assign MEM_W_DATA = r_wdata;
   // Built only from async-reset flops, so the enables fall the moment
   // RST_N asserts and no write can land on the following edge.
   assign MEM_W_EN   = ((r_state == S_ACCESS) && r_write) ? r_strb : '0;

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_ram_port_ctrl
//  Purpose  : Scoreboard bench for dp_ram_port_ctrl (WIDTH=32, 4 byte lanes)
//             with a behavioural RAM. The RAM can inject arbitration losses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_ram_port_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic        REQ_VALID = 1'b0;
   logic        REQ_READY;
   logic        REQ_WRITE = 1'b0;
   logic [2:0]  REQ_ADDR = '0;
   logic [31:0] REQ_WDATA = '0;
   logic [3:0]  REQ_STRB = '0;
   logic        RSP_VALID;
   logic        RSP_READY = 1'b1;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic [2:0]  MEM_ADDR;
   logic [31:0] MEM_W_DATA;
   logic [3:0]  MEM_W_EN;
   logic [31:0] MEM_R_DATA;
   logic        MEM_ARB_ERR;

   int checks   = 0;
   int failures = 0;

   // {err, rdata}
   logic [32:0] exp_q[$];
   logic [32:0] exp_e;

   logic [31:0] mem [8] = '{default: '0};
   int          attempts    = 0;
   int          arb_base    = 0;
   int          arb_fail_n  = 0;

   always #5 CLK = ~CLK;

   dp_ram_port_ctrl #(
      .WIDTH      (32),
      .DEPTH      (8),
      .STRB_WIDTH (8),
      .MAX_RETRY  (4)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .REQ_VALID   (REQ_VALID),
      .REQ_READY   (REQ_READY),
      .REQ_WRITE   (REQ_WRITE),
      .REQ_ADDR    (REQ_ADDR),
      .REQ_WDATA   (REQ_WDATA),
      .REQ_STRB    (REQ_STRB),
      .RSP_VALID   (RSP_VALID),
      .RSP_READY   (RSP_READY),
      .RSP_RDATA   (RSP_RDATA),
      .RSP_ERR     (RSP_ERR),
      .MEM_ADDR    (MEM_ADDR),
      .MEM_W_DATA  (MEM_W_DATA),
      .MEM_W_EN    (MEM_W_EN),
      .MEM_R_DATA  (MEM_R_DATA),
      .MEM_ARB_ERR (MEM_ARB_ERR)
   );

   // Behavioural RAM: combinational read, byte-lane write at the edge.
   // The first arb_fail_n write attempts after arming are suppressed.
   assign MEM_R_DATA  = mem[MEM_ADDR];
   assign MEM_ARB_ERR = (MEM_W_EN != 4'b0) && ((attempts - arb_base) < arb_fail_n);

   always @(posedge CLK) begin
      if (MEM_W_EN != 4'b0) begin
         attempts <= attempts + 1;
         if (!MEM_ARB_ERR) begin
            for (int b = 0; b < 4; b++) begin
               if (MEM_W_EN[b]) mem[MEM_ADDR][8*b +: 8] <= MEM_W_DATA[8*b +: 8];
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per response handshake.
   always @(negedge CLK) begin
      if (RST_N === 1'b1 && RSP_VALID === 1'b1 && RSP_READY === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got rdata=%h err=%b required no response",
                     RSP_RDATA, RSP_ERR);
         end else begin
            exp_e = exp_q.pop_front();
            check("rsp_rdata", RSP_RDATA, exp_e[31:0]);
            check("rsp_err", {31'b0, RSP_ERR}, {31'b0, exp_e[32]});
         end
      end
   end

   // Issue one request, push its expected response, return #1 after the
   // accept edge. Fields are scrambled afterwards so late sampling shows up.
   task automatic issue(input bit w, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] er, input bit ee,
                        input bit lat, output int waits);
      int n;
      exp_q.push_back({ee, er});
      REQ_VALID = 1'b1;
      REQ_WRITE = w;
      REQ_ADDR  = a;
      REQ_WDATA = d;
      REQ_STRB  = s;
      n = 0;
      @(negedge CLK);
      while (REQ_READY !== 1'b1 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: got REQ_READY=%b required 1 within 50 cycles", REQ_READY);
      end
      waits = n;
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      REQ_WRITE = ~w;
      REQ_ADDR  = a + 3'd1;
      REQ_WDATA = ~d;
      REQ_STRB  = ~s;
      if (lat) begin
         check("lat_access_no_valid", {31'b0, RSP_VALID}, 32'd0);
         @(posedge CLK);
         #1;
         check("lat_resp_valid", {31'b0, RSP_VALID}, 32'd1);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending responses required 0", exp_q.size());
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int waits;

      // 1: reset state and first-cycle REQ_READY
      #2 RST_N = 1'b0;
      #1;
      check("rst_req_ready", {31'b0, REQ_READY}, 32'd0);
      check("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
      check("rst_w_en", {28'b0, MEM_W_EN}, 32'd0);
      check("rst_mem_addr", {29'b0, MEM_ADDR}, 32'd0);
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;
      check("rel_req_ready_low", {31'b0, REQ_READY}, 32'd0);
      @(posedge CLK);
      #1;
      check("rel_req_ready_high", {31'b0, REQ_READY}, 32'd1);

      // 2: write A5 lane 0 to addr 3, read it back, both with latency checks
      issue(1'b1, 3'd3, 32'h0000_00A5, 4'b0001, 32'h0, 1'b0, 1'b1, waits);
      issue(1'b0, 3'd3, 32'h0, 4'b0000, 32'h0000_00A5, 1'b0, 1'b1, waits);

      // 3: full write then partial-lane write, read merged word
      issue(1'b1, 3'd5, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b0, waits);
      issue(1'b1, 3'd5, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b0, 1'b0, waits);
      issue(1'b0, 3'd5, 32'h0, 4'b0000, 32'h11FF_33FF, 1'b0, 1'b0, waits);
      wait_drain();

      // 4: response back-pressure, then same-edge accept on release
      RSP_READY = 1'b0;
      issue(1'b0, 3'd5, 32'h0, 4'b0000, 32'h11FF_33FF, 1'b0, 1'b1, waits);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("stall_rsp_valid", {31'b0, RSP_VALID}, 32'd1);
         check("stall_rdata", RSP_RDATA, 32'h11FF_33FF);
         check("stall_err", {31'b0, RSP_ERR}, 32'd0);
         check("stall_req_ready", {31'b0, REQ_READY}, 32'd0);
      end
      @(posedge CLK);
      #1 RSP_READY = 1'b1;
      issue(1'b0, 3'd3, 32'h0, 4'b0000, 32'h0000_00A5, 1'b0, 1'b1, waits);
      check("same_edge_accept_waits", 32'(waits), 32'd0);
      wait_drain();

      // 5a: two arbitration losses, third attempt lands
      arb_base   = attempts;
      arb_fail_n = 2;
      issue(1'b1, 3'd2, 32'hCAFE_BABE, 4'hF, 32'h0, 1'b0, 1'b0, waits);
      wait_drain();
      check("retry_ok_attempts", 32'(attempts - arb_base), 32'd3);
      issue(1'b0, 3'd2, 32'h0, 4'b0000, 32'hCAFE_BABE, 1'b0, 1'b0, waits);
      wait_drain();

      // 5b: arbitration lost every time, abandoned after 4 attempts
      issue(1'b1, 3'd6, 32'h0102_0304, 4'hF, 32'h0, 1'b0, 1'b0, waits);
      wait_drain();
      arb_base   = attempts;
      arb_fail_n = 1000;
      issue(1'b1, 3'd6, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 1'b0, waits);
      wait_drain();
      check("retry_err_attempts", 32'(attempts - arb_base), 32'd4);
      arb_fail_n = 0;
      issue(1'b0, 3'd6, 32'h0, 4'b0000, 32'h0102_0304, 1'b0, 1'b0, waits);
      wait_drain();

      // 6: reset during the ACCESS cycle of a write
      REQ_VALID = 1'b1;
      REQ_WRITE = 1'b1;
      REQ_ADDR  = 3'd1;
      REQ_WDATA = 32'h5A5A_5A5A;
      REQ_STRB  = 4'hF;
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      check("mid_rst_w_en_before", {28'b0, MEM_W_EN}, 32'h0000_000F);
      #3 RST_N = 1'b0;
      #1;
      check("mid_rst_w_en", {28'b0, MEM_W_EN}, 32'd0);
      check("mid_rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
      check("mid_rst_req_ready", {31'b0, REQ_READY}, 32'd0);
      @(posedge CLK);
      #1;
      check("mid_rst_mem_word", mem[1], 32'h0);
      @(posedge CLK);
      #1 RST_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("post_rst_no_rsp", {31'b0, RSP_VALID}, 32'd0);
      end
      check("post_rst_mem_word", mem[1], 32'h0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
